// File: rtl/button_debounce.sv
// Two-flop synchronizer and debouncer for the board push button, with press/release/long-press
// pulses and a wrapping press counter. Long-press logic is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 160000,
  parameter int unsigned LONG_CYCLES     = 16000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WF_BUTTON,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  // Pin value seen while the button is not pressed.
  localparam logic RelPin = ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("LONG_CYCLES must be >= 1");
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressed,
    StHeldLong
  } state_e;

  logic [HoldW-1:0] hold_q, hold_d;
`else
  typedef enum logic [1:0] {
    StReleased,
    StPressed
  } state_e;
`endif

  state_e         state_q, state_d;
  logic           sync1_q, sync2_q;
  logic           sync;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;
  logic [7:0]     count_q, count_d;
  logic           mismatch, db_hit, rise, fall;

  assign sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    mismatch = (sync != level_q);
    db_hit   = mismatch && (db_cnt_q == DbMax);
    db_cnt_d = (!mismatch || db_hit) ? '0 : db_cnt_q + 1'b1;
    level_d  = db_hit ? ~level_q : level_q;
    rise     = db_hit && !level_q;
    fall     = db_hit && level_q;
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    count_d   = count_q;
`ifdef BUTTON_LONG_PRESS_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      StReleased: begin
        if (rise) begin
          state_d = StPressed;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
`ifdef BUTTON_LONG_PRESS_EN
          hold_d  = '0;
`endif
        end
      end
      StPressed: begin
        // A fall takes priority over a hold expiry on the same edge.
        if (fall) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end
`ifdef BUTTON_LONG_PRESS_EN
        else begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HoldMax) begin
            long_d  = 1'b1;
            state_d = StHeldLong;
          end
        end
      end
      StHeldLong: begin
        if (fall) begin
          state_d   = StReleased;
          release_d = 1'b1;
        end
`endif
      end
      default: state_d = StReleased;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= RelPin;
      sync2_q   <= RelPin;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= StReleased;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= 8'd0;
`ifdef BUTTON_LONG_PRESS_EN
      hold_q    <= '0;
`endif
    end else begin
      sync1_q   <= WF_BUTTON;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
`ifdef BUTTON_LONG_PRESS_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pin = 1'b1;
  logic       btn_level, btn_press, btn_release, btn_long;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .WF_BUTTON  (pin),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pin = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pin = 1'b1;
    repeat (3) tick();
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b want 0", btn_level); end
    total++; if (btn_press !== 1'b0) begin bad++; $display("FAIL reset_press: got %b want 0", btn_press); end
    total++; if (btn_release !== 1'b0) begin bad++; $display("FAIL reset_release: got %b want 0", btn_release); end
    total++; if (btn_long !== 1'b0) begin bad++; $display("FAIL reset_long: got %b want 0", btn_long); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", press_count); end
    rst = 1'b0;
    repeat (10) tick();
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL idle_level: got %b want 0", btn_level); end
  endtask

  task automatic test_clean_press();
    int rise_e, press_e, npress, nrel, fall_e, rel_e;
    do_reset();
    pin = 1'b0;
    rise_e = -1; press_e = -1; npress = 0; nrel = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btn_level === 1'b1 && rise_e < 0) rise_e = k;
      if (btn_press === 1'b1) begin npress++; if (press_e < 0) press_e = k; end
      if (btn_release === 1'b1) nrel++;
    end
    total++; if (rise_e !== 6) begin bad++; $display("FAIL press_rise_edge: got %0d want 6", rise_e); end
    total++; if (press_e !== 6) begin bad++; $display("FAIL press_pulse_edge: got %0d want 6", press_e); end
    total++; if (npress !== 1) begin bad++; $display("FAIL press_pulse_count: got %0d want 1", npress); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL press_count: got %0d want 1", press_count); end
    total++; if (nrel !== 0) begin bad++; $display("FAIL press_no_release: got %0d want 0", nrel); end
    pin = 1'b1;
    fall_e = -1; rel_e = -1; nrel = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btn_level === 1'b0 && fall_e < 0) fall_e = k;
      if (btn_release === 1'b1) begin nrel++; if (rel_e < 0) rel_e = k; end
    end
    total++; if (fall_e !== 6) begin bad++; $display("FAIL release_fall_edge: got %0d want 6", fall_e); end
    total++; if (rel_e !== 6) begin bad++; $display("FAIL release_pulse_edge: got %0d want 6", rel_e); end
    total++; if (nrel !== 1) begin bad++; $display("FAIL release_pulse_count: got %0d want 1", nrel); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL release_count_kept: got %0d want 1", press_count); end
  endtask

  task automatic test_bounce();
    int npress, nrel;
    do_reset();
    npress = 0; nrel = 0;
    for (int seg = 0; seg < 6; seg++) begin
      pin = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick();
        if (btn_press === 1'b1) npress++;
        if (btn_release === 1'b1) nrel++;
      end
    end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL bounce_level_during: got %b want 0", btn_level); end
    pin = 1'b0;
    repeat (14) begin
      tick();
      if (btn_press === 1'b1) npress++;
      if (btn_release === 1'b1) nrel++;
    end
    total++; if (npress !== 1) begin bad++; $display("FAIL bounce_press_count: got %0d want 1", npress); end
    total++; if (nrel !== 0) begin bad++; $display("FAIL bounce_release_count: got %0d want 0", nrel); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL bounce_counter: got %0d want 1", press_count); end
  endtask

  task automatic test_long_hold();
    int rise_e, nlong, long_e, exp_nlong, exp_long_e, nrel, rel_e;
`ifdef BUTTON_LONG_PRESS_EN
    exp_nlong = 1; exp_long_e = 20;
`else
    exp_nlong = 0; exp_long_e = -1;
`endif
    do_reset();
    pin = 1'b0;
    rise_e = -1;
    for (int k = 1; k <= 20 && rise_e < 0; k++) begin
      tick();
      if (btn_level === 1'b1) rise_e = k;
    end
    total++; if (rise_e !== 6) begin bad++; $display("FAIL long_rise_edge: got %0d want 6", rise_e); end
    nlong = 0; long_e = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (btn_long === 1'b1) begin nlong++; if (long_e < 0) long_e = k; end
    end
    total++; if (nlong !== exp_nlong) begin bad++; $display("FAIL long_pulse_count: got %0d want %0d", nlong, exp_nlong); end
    total++; if (long_e !== exp_long_e) begin bad++; $display("FAIL long_pulse_edge: got %0d want %0d", long_e, exp_long_e); end
    pin = 1'b1;
    nrel = 0; rel_e = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_release === 1'b1) begin nrel++; if (rel_e < 0) rel_e = k; end
      if (btn_long === 1'b1) nlong++;
    end
    total++; if (rel_e !== 6) begin bad++; $display("FAIL long_release_edge: got %0d want 6", rel_e); end
    total++; if (nrel !== 1) begin bad++; $display("FAIL long_release_count: got %0d want 1", nrel); end
    total++; if (nlong !== exp_nlong) begin bad++; $display("FAIL long_no_extra_pulse: got %0d want %0d", nlong, exp_nlong); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL long_level_after: got %b want 0", btn_level); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      pin = 1'b0;
      repeat (8) tick();
      if (n == 1) begin
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL wrap_first: got %0d want 1", press_count); end
      end
      if (n == 255) begin
        total++; if (press_count !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", press_count); end
      end
      if (n == 256) begin
        total++; if (press_count !== 8'd0) begin bad++; $display("FAIL wrap_256: got %0d want 0", press_count); end
      end
      pin = 1'b1;
      repeat (8) tick();
    end
  endtask

  task automatic test_reset_mid_press();
    int press_e, nrel;
    do_reset();
    pin = 1'b0;
    repeat (10) tick();
    total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL midrst_pre_level: got %b want 1", btn_level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL midrst_level: got %b want 0", btn_level); end
    total++; if (btn_release !== 1'b0) begin bad++; $display("FAIL midrst_release: got %b want 0", btn_release); end
    total++; if (btn_press !== 1'b0) begin bad++; $display("FAIL midrst_press: got %b want 0", btn_press); end
    total++; if (btn_long !== 1'b0) begin bad++; $display("FAIL midrst_long: got %b want 0", btn_long); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", press_count); end
    press_e = -1; nrel = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (btn_press === 1'b1 && press_e < 0) press_e = k;
      if (btn_release === 1'b1) nrel++;
    end
    total++; if (press_e !== 6) begin bad++; $display("FAIL midrst_repress_edge: got %0d want 6", press_e); end
    total++; if (press_count !== 8'd1) begin bad++; $display("FAIL midrst_repress_count: got %0d want 1", press_count); end
    total++; if (nrel !== 0) begin bad++; $display("FAIL midrst_no_release: got %0d want 0", nrel); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_wrap();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
